// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with a valid/ready handshake.
// It has a main entry that drives the outputs and a skid entry that absorbs
// one word of backpressure. It also supports synchronous flush, external hold
// and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_free;

  // in_ready depends only on stored state, so it has no path from out_ready or hold.
  assign in_ready    = ~r_skid_valid;
  assign w_in_fire   = in_valid & ~r_skid_valid;
  assign w_out_fire  = r_main_valid & out_ready & ~hold;
  assign w_main_free = ~r_main_valid | w_out_fire;

  // Main entry: refill from the skid first, then from the input; otherwise go empty with zeroed payload.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_main_ctrl  <= r_skid_ctrl;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data;
        r_main_ctrl  <= in_ctrl;
      end else begin
        r_main_valid <= 1'b0;
        r_main_data  <= '0;
        r_main_ctrl  <= '0;
      end
    end
  end

  // Skid entry: captures an accepted word when main is occupied and not draining; empties once main takes it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else if (r_main_valid && !w_out_fire && w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
      r_skid_ctrl  <= in_ctrl;
    end else if (w_main_free && r_skid_valid) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end
  end

  // Stall counter: counts cycles where a word is presented but does not leave. Flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !w_out_fire && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = r_main_valid;
  assign out_data  = r_main_valid ? r_main_data : '0;
  assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. It drives inputs 1 time unit after
// each rising edge and then compares the registered outputs against values
// worked out by hand.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, hold;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic [1:0]    eo;
    logic          er;
    logic [NW-1:0] es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [DW-1:0] id, logic [CW-1:0] ic, logic ordy,
                              logic ev, logic [DW-1:0] ed, logic [CW-1:0] ec,
                              logic [1:0] eo, logic er, logic [NW-1:0] es);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.er = er; v.es = es;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic iv, logic [DW-1:0] id, logic [CW-1:0] ic,
                       logic ordy, logic hld, logic fl);
    in_valid = iv; in_data = id; in_ctrl = ic;
    out_ready = ordy; hold = hld; flush = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Streaming: word k presented one cycle after acceptance, one in flight.
    for (int unsigned k = 1; k <= 8; k++)
      tbl.push_back(mk(1'b1, DW'(k), 8'h01, 1'b1, 1'b1, DW'(k), 8'h01, 2'd1, 1'b1, 4'd0));
    tbl.push_back(mk(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b1, 4'd0));
    // Backpressure: A accepted, B goes into the skid, C waits upstream, and the words drain in order.
    tbl.push_back(mk(1'b1, 16'h000A, 8'h02, 1'b1, 1'b1, 16'h000A, 8'h02, 2'd1, 1'b1, 4'd0));
    tbl.push_back(mk(1'b1, 16'h000B, 8'h03, 1'b0, 1'b1, 16'h000A, 8'h02, 2'd2, 1'b0, 4'd1));
    tbl.push_back(mk(1'b1, 16'h000C, 8'h04, 1'b0, 1'b1, 16'h000A, 8'h02, 2'd2, 1'b0, 4'd2));
    tbl.push_back(mk(1'b1, 16'h000C, 8'h04, 1'b0, 1'b1, 16'h000A, 8'h02, 2'd2, 1'b0, 4'd3));
    tbl.push_back(mk(1'b1, 16'h000C, 8'h04, 1'b1, 1'b1, 16'h000B, 8'h03, 2'd1, 1'b1, 4'd3));
    tbl.push_back(mk(1'b1, 16'h000C, 8'h04, 1'b1, 1'b1, 16'h000C, 8'h04, 2'd1, 1'b1, 4'd3));
    tbl.push_back(mk(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b1, 4'd3));

    do_reset();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_ctrl", 32'(out_ctrl), 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ic, tbl[i].ordy, 1'b0, 1'b0);
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d out_ctrl", i), 32'(out_ctrl), 32'(tbl[i].ec));
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(tbl[i].eo));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].es));
    end

    // Flush with both entries full and 0xFF offered in the flush cycle.
    do_reset();
    drive(1'b1, 16'h0011, 8'h03, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 8'h05, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fill occupancy", 32'(occupancy), 32'd2);
    chk("fill in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h00FF, 8'h07, 1'b0, 1'b0, 1'b1);
    tick();
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush out_data", 32'(out_data), 32'd0);
    chk("flush out_ctrl", 32'(out_ctrl), 32'd0);
    chk("flush occupancy", 32'(occupancy), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    chk("flush keeps stall_cnt", 32'(stall_cnt), 32'd2);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("post-flush no 0xFF", 32'(out_valid), 32'd0);
    end

    // Flush with hold still empties the stage.
    drive(1'b1, 16'h0033, 8'h01, 1'b1, 1'b1, 1'b0);
    tick();
    chk("hold-flush loaded", 32'(out_data), 32'h33);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("hold-flush out_valid", 32'(out_valid), 32'd0);

    // Hold with out_ready=1 holds 0x5 for 4 cycles.
    do_reset();
    drive(1'b1, 16'h0005, 8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    chk("hold load", 32'(out_data), 32'h5);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("hold%0d out_data", i), 32'(out_data), 32'h5);
      chk($sformatf("hold%0d stall_cnt", i), 32'(stall_cnt), 32'(i));
    end
    chk("hold occupancy", 32'(occupancy), 32'd1);
    hold = 1'b0;
    tick();
    chk("hold release transfer", 32'(out_valid), 32'd0);
    chk("hold release stall_cnt", 32'(stall_cnt), 32'd4);

    // Hold for 20 cycles with a 4-bit counter saturates it at 15, and reset clears it.
    do_reset();
    drive(1'b1, 16'h0007, 8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) chk("sat reach 15", 32'(stall_cnt), 32'd15);
    end
    chk("sat stays 15", 32'(stall_cnt), 32'd15);
    chk("sat out_data", 32'(out_data), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and external hold. It replaces the fixed-field, stall-only inter-stage registers between decode, execute and memory. Any bundle of stage fields can be passed through as an opaque data word plus a control word. Control bits are zeroed on flush or drain, so a flushed or empty stage always presents a bubble (RegW/MemR/MemW = 0).

## Interface
Parameters:
- DATA_W, 128, width of the opaque data payload (imm, operands, register IDs)
- CTRL_W, 16, width of the control payload (ALUop, RegW, ALUSrc, MemR, MemW, …); zero means no side effect
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of both entries (branch/exception squash)
- hold  in  1  external stall; while high, no entry leaves the stage
- in_valid  in  1  upstream has a word
- in_ready  out  1  stage can accept; registered, equals NOT skid_valid
- in_data  in  DATA_W  upstream data
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  main entry occupied
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main entry data; 0 when out_valid = 0
- out_ctrl  out  CTRL_W  main entry control; 0 when out_valid = 0
- occupancy  out  2  number of held entries (0, 1, 2)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and no output transfer, saturating

## Operation
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready & ~hold.
- Storage: main entry (drives outputs) and skid entry; each has a valid bit plus data/ctrl.
- Priority per cycle: rst > flush > normal update.
- Normal update for the main entry:
  - If main is empty or out_fire, main loads the skid entry when skid is valid, else the input when in_fire.
  - If neither source is available, main becomes empty and its data/ctrl clear to 0.
- Normal update for the skid entry: if main is valid, out_fire = 0 and in_fire, the skid loads the input.
- in_ready is low whenever the skid is valid, so the input never loads while the skid is occupied.
- Flush: both valid bits go to 0 and all data/ctrl clear to 0. An in_fire in the flush cycle is discarded. An out_fire in the flush cycle still counts as a completed transfer for downstream.
- occupancy = main_valid + skid_valid. The skid is never valid while main is empty.
- stall_cnt increments by 1 each cycle with out_valid & ~out_fire. It saturates at 2^CNT_W−1 and is cleared only by rst, not by flush.
- Order preserved: strict FIFO across the two entries. No word is duplicated or dropped except by flush.

## Timing
- Reset values: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, in_ready=1 (first cycle after rst deasserts).
- Latency: a word accepted at edge N appears on out_* after edge N (one cycle) when the stage was empty.
- Throughput: one word per cycle sustained while out_ready=1 and hold=0.
- in_ready deasserts the cycle after the skid fills, and reasserts the cycle after the skid drains into main. in_ready has no combinational path from out_ready or hold.
- hold=1 with out_ready=1: no transfer; the stage behaves as out_ready=0.
- Simultaneous flush and rst: rst result. Simultaneous flush with hold: flush wins, stage empties.
- rst mid-transfer: all state returns to reset values at that edge; in-flight words are lost.

## Test plan
- Reset, then stream 8 words (data 1..8, ctrl 0x0001) with out_ready=1 -> out_* shows 1..8 on consecutive cycles, one cycle after input, occupancy=1 throughout, stall_cnt=0.
- Accept 0xA, then drop out_ready for 3 cycles while offering 0xB, 0xC:
  - 0xB goes into the skid and in_ready=0 the next cycle; 0xC is held upstream.
  - occupancy=2 and stall_cnt=3.
  - After out_ready rises, the order out is 0xA, 0xB, 0xC.
- Fill both entries, assert flush for 1 cycle with in_valid=1 (data 0xFF) -> the next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1; 0xFF is never output.
- hold=1 for 4 cycles with out_ready=1 and main valid (0x5) -> out_data stays 0x5 and no transfer occurs; stall_cnt +4; 0x5 transfers the first cycle after hold falls.
- CNT_W=4, hold for 20 cycles with main valid -> stall_cnt saturates at 15. Assert rst -> stall_cnt=0, in_ready=1 after the reset edge.
